// File: rtl/pipe_pkg.sv
// -----------------------------------------------------------------------------
// pipe_pkg
// Shared definitions for the ID/EXE pipeline boundary: skid-buffer state
// encoding, register tag width, control-bit positions and the packed payload
// layout that ID packs and EXE unpacks.
// -----------------------------------------------------------------------------
package pipe_pkg;

    localparam int SRC_W  = 4;
    localparam int CTRL_W = 7;

    // Control bit positions inside the payload LSBs.
    localparam int WB_EN_B = 6;
    localparam int MEM_R_B = 5;
    localparam int MEM_W_B = 4;
    localparam int IMM_B   = 3;
    localparam int BR_B    = 2;
    localparam int S_B     = 1;
    localparam int C_B     = 0;

    // Encoded as {skid.valid, main.valid}; 2'b10 cannot occur.
    typedef enum logic [1:0] {
        EMPTY = 2'b00,
        ONE   = 2'b01,
        TWO   = 2'b11
    } state_e;

    typedef struct packed {
        logic wb_en;
        logic mem_read;
        logic mem_write;
        logic imm;
        logic branch;
        logic s;
        logic carry;
    } ctrl_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] val_rn;
        logic [31:0] val_rm;
        logic [31:0] instr;
        logic [11:0] shift_op;
        logic [23:0] signed_imm;
        logic [3:0]  dest;
        logic [3:0]  exe_cmd;
        logic        flags;      // status carry-in
        ctrl_t       ctrl;       // occupies the CTRL_W LSBs
    } id_ex_payload_t;

    localparam int PAYLOAD_BITS = $bits(id_ex_payload_t);

endpackage

// File: rtl/id_ex_skid_reg_if.sv
// -----------------------------------------------------------------------------
// id_ex_skid_reg_if
// Valid/ready stage handshake carrying the packed payload and source tags.
//   master: drives valid, payload, src1, src2; receives ready
//   slave : receives valid, payload, src1, src2; drives ready
// -----------------------------------------------------------------------------
interface id_ex_skid_reg_if #(
    parameter int PAYLOAD_W = 180,
    parameter int SRC_W     = 4
);
    logic                 valid;
    logic                 ready;
    logic [PAYLOAD_W-1:0] payload;
    logic [SRC_W-1:0]     src1;
    logic [SRC_W-1:0]     src2;

    modport master (output valid, payload, src1, src2, input ready);
    modport slave  (input valid, payload, src1, src2, output ready);
endinterface

// File: rtl/pipe_slot.sv
// -----------------------------------------------------------------------------
// pipe_slot
// One storage entry: payload, two source tags and a valid bit.
//   clk, rst          : clock, asynchronous active-high reset
//   load              : capture d_* and set valid
//   clear             : empty the entry and zero its contents (wins over load)
//   d_payload/src1/2  : data to capture
//   q_valid/payload/src1/src2 : stored entry
// -----------------------------------------------------------------------------
module pipe_slot #(
    parameter int PAYLOAD_W = 180,
    parameter int SRC_W     = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 load,
    input  logic                 clear,
    input  logic [PAYLOAD_W-1:0] d_payload,
    input  logic [SRC_W-1:0]     d_src1,
    input  logic [SRC_W-1:0]     d_src2,
    output logic                 q_valid,
    output logic [PAYLOAD_W-1:0] q_payload,
    output logic [SRC_W-1:0]     q_src1,
    output logic [SRC_W-1:0]     q_src2
);

    logic                 valid_d,   valid_q;
    logic [PAYLOAD_W-1:0] payload_d, payload_q;
    logic [SRC_W-1:0]     src1_d,    src1_q;
    logic [SRC_W-1:0]     src2_d,    src2_q;

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path leaves a value unassigned and no latch is inferred.
        valid_d   = valid_q;
        payload_d = payload_q;
        src1_d    = src1_q;
        src2_d    = src2_q;
        if (clear) begin
            valid_d   = 1'b0;
            payload_d = '0;
            src1_d    = '0;
            src2_d    = '0;
        end else if (load) begin
            valid_d   = 1'b1;
            payload_d = d_payload;
            src1_d    = d_src1;
            src2_d    = d_src2;
        end
    end

    // NOTE: the data registers are reset as well as the valid bit; the tags feed hazard logic and must never show stale values after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: non-blocking assignments in clocked blocks so every flop samples pre-edge values regardless of statement order.
            valid_q   <= 1'b0;
            payload_q <= '0;
            src1_q    <= '0;
            src2_q    <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
            src1_q    <= src1_d;
            src2_q    <= src2_d;
        end
    end

    assign q_valid   = valid_q;
    assign q_payload = payload_q;
    assign q_src1    = src1_q;
    assign q_src2    = src2_q;

endmodule

// File: rtl/id_ex_skid_reg.sv
// -----------------------------------------------------------------------------
// id_ex_skid_reg
// ID->EXE boundary register with a two-entry skid buffer. The main slot drives
// the EXE side; the skid slot absorbs the one instruction that was accepted in
// the cycle EXE stalled, so in_ready can be registered.
//   clk, rst    : clock, asynchronous active-high reset
//   flush       : synchronous flush, drops everything incl. the incoming entry
//   in_if       : ID-side handshake (slave)
//   out_if      : EXE-side handshake (master); control LSBs gated by valid
//   occupancy   : entries held, 0..2
//   bubble_cnt  : saturating count of edges with out_valid low
// -----------------------------------------------------------------------------
module id_ex_skid_reg #(
    parameter int PAYLOAD_W = 180,
    parameter int CTRL_W    = 7,
    parameter int SRC_W     = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    id_ex_skid_reg_if.slave         in_if,
    id_ex_skid_reg_if.master        out_if,
    output logic [1:0]              occupancy,
    output logic [15:0]             bubble_cnt
);
    import pipe_pkg::*;

    logic                 m_v, s_v;
    logic [PAYLOAD_W-1:0] m_payload, s_payload, m_d_payload;
    logic [SRC_W-1:0]     m_src1, m_src2, s_src1, s_src2, m_d_src1, m_d_src2;
    logic                 m_load, m_clear, m_from_skid, s_load, s_clear;
    logic                 in_ready_d, in_ready_q;
    logic [15:0]          bubble_d, bubble_q;
    logic                 in_fire, out_fire;
    state_e               state, state_d;

    // The slot valid bits are the state register.
    assign state    = state_e'({s_v, m_v});
    assign in_fire  = in_if.valid & in_ready_q;
    assign out_fire = m_v & out_if.ready;

    always_comb begin
        state_d     = state;
        m_load      = 1'b0;
        m_clear     = 1'b0;
        m_from_skid = 1'b0;
        s_load      = 1'b0;
        s_clear     = 1'b0;
        if (flush) begin
            m_clear = 1'b1;
            s_clear = 1'b1;
            state_d = EMPTY;
        end else begin
            case (state)
                EMPTY: begin
                    if (in_fire) begin
                        m_load  = 1'b1;
                        state_d = ONE;
                    end
                end
                ONE: begin
                    if (in_fire && out_fire) begin
                        m_load = 1'b1;
                    end else if (in_fire) begin
                        s_load  = 1'b1;
                        state_d = TWO;
                    end else if (out_fire) begin
                        m_clear = 1'b1;
                        state_d = EMPTY;
                    end
                end
                TWO: begin
                    if (out_fire) begin
                        m_load      = 1'b1;
                        m_from_skid = 1'b1;
                        s_clear     = 1'b1;
                        state_d     = ONE;
                    end
                end
                default: begin
                    m_clear = 1'b1;
                    s_clear = 1'b1;
                    state_d = EMPTY;
                end
            endcase
        end
    end

    assign m_d_payload = m_from_skid ? s_payload : in_if.payload;
    assign m_d_src1    = m_from_skid ? s_src1    : in_if.src1;
    assign m_d_src2    = m_from_skid ? s_src2    : in_if.src2;

    pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .SRC_W(SRC_W)) u_main (
        .clk       (clk),
        .rst       (rst),
        .load      (m_load),
        .clear     (m_clear),
        .d_payload (m_d_payload),
        .d_src1    (m_d_src1),
        .d_src2    (m_d_src2),
        .q_valid   (m_v),
        .q_payload (m_payload),
        .q_src1    (m_src1),
        .q_src2    (m_src2)
    );

    pipe_slot #(.PAYLOAD_W(PAYLOAD_W), .SRC_W(SRC_W)) u_skid (
        .clk       (clk),
        .rst       (rst),
        .load      (s_load),
        .clear     (s_clear),
        .d_payload (in_if.payload),
        .d_src1    (in_if.src1),
        .d_src2    (in_if.src2),
        .q_valid   (s_v),
        .q_payload (s_payload),
        .q_src1    (s_src1),
        .q_src2    (s_src2)
    );

    // in_ready is a function of the next state only, never of out_ready.
    assign in_ready_d = (state_d != TWO);
    assign bubble_d   = (!m_v && bubble_q != 16'hFFFF) ? bubble_q + 16'd1 : bubble_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready_q <= 1'b1;
            bubble_q   <= '0;
        end else begin
            in_ready_q <= in_ready_d;
            bubble_q   <= bubble_d;
        end
    end

    assign in_if.ready    = in_ready_q;
    assign out_if.valid   = m_v;
    assign out_if.payload = {m_payload[PAYLOAD_W-1:CTRL_W], m_payload[CTRL_W-1:0] & {CTRL_W{m_v}}};
    assign out_if.src1    = m_src1;
    assign out_if.src2    = m_src2;
    assign occupancy      = {1'b0, m_v} + {1'b0, s_v};
    assign bubble_cnt     = bubble_q;

endmodule

// File: tb/tb_id_ex_skid_reg.sv
module tb_id_ex_skid_reg;
    import pipe_pkg::*;

    localparam int PW = 180;
    localparam int CW = 7;
    localparam int SW = 4;

    typedef struct packed {
        logic [PW-1:0] payload;
        logic [SW-1:0] src1;
        logic [SW-1:0] src2;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic [1:0]  occupancy;
    logic [15:0] bubble_cnt;

    int   checks = 0;
    int   errors = 0;
    exp_t sb_q[$];
    exp_t mon_e;

    always #5 clk = ~clk;

    id_ex_skid_reg_if #(.PAYLOAD_W(PW), .SRC_W(SW)) in_if ();
    id_ex_skid_reg_if #(.PAYLOAD_W(PW), .SRC_W(SW)) out_if ();

    id_ex_skid_reg #(.PAYLOAD_W(PW), .CTRL_W(CW), .SRC_W(SW)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_if      (in_if),
        .out_if     (out_if),
        .occupancy  (occupancy),
        .bubble_cnt (bubble_cnt)
    );

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [PW-1:0] mk_pl(input int n);
        id_ex_payload_t p;
        p            = '0;
        p.pc         = 32'(n * 4);
        p.val_rn     = 32'(n) * 32'h0101_0101;
        p.val_rm     = ~(32'(n) * 32'h0011_0011);
        p.instr      = 32'hE080_0000 | 32'(n);
        p.signed_imm = 24'(n * 3);
        p.dest       = 4'(n);
        p.exe_cmd    = 4'(n + 1);
        p.ctrl       = 7'h40 | 7'(n);
        return p;
    endfunction

    task automatic drive(input logic v, input logic [PW-1:0] pl, input int s1, input int s2,
                         input logic rdy);
        in_if.valid   = v;
        in_if.payload = pl;
        in_if.src1    = SW'(s1);
        in_if.src2    = SW'(s2);
        out_if.ready  = rdy;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_in_ready"},  256'(in_if.ready),    256'(1));
        check({tag, "_out_valid"}, 256'(out_if.valid),   256'(0));
        check({tag, "_payload"},   256'(out_if.payload), 256'(0));
        check({tag, "_src"},       256'({out_if.src1, out_if.src2}), 256'(0));
        check({tag, "_occ"},       256'(occupancy),      256'(0));
        check({tag, "_bubble"},    256'(bubble_cnt),     256'(0));
    endtask

    // Scoreboard: sampled mid-cycle, so these reflect what fires on the next edge.
    always @(negedge clk) begin
        if (rst || flush) begin
            sb_q.delete();
        end else begin
            if (out_if.valid && out_if.ready) begin
                check("sb_nonempty", 256'(sb_q.size() > 0), 256'(1));
                if (sb_q.size() > 0) begin
                    mon_e = sb_q.pop_front();
                    check("sb_payload", 256'(out_if.payload), 256'(mon_e.payload));
                    check("sb_src", 256'({out_if.src1, out_if.src2}), 256'({mon_e.src1, mon_e.src2}));
                end
            end
            if (in_if.valid && in_if.ready) begin
                mon_e.payload = in_if.payload;
                mon_e.src1    = in_if.src1;
                mon_e.src2    = in_if.src2;
                sb_q.push_back(mon_e);
            end
        end
    end

    initial begin
        logic [PW-1:0] pl;

        rst   = 1'b1;
        flush = 1'b0;
        drive(1'b0, '0, 0, 0, 1'b0);
        tick();
        tick();
        check_reset_vals("rst");

        // Back-to-back flow, no stalls.
        rst = 1'b0;
        for (int n = 1; n <= 4; n++) begin
            drive(1'b1, mk_pl(n), n, n + 1, 1'b1);
            tick();
            check("flow_payload", 256'(out_if.payload), 256'(mk_pl(n)));
            check("flow_src", 256'({out_if.src1, out_if.src2}), 256'({SW'(n), SW'(n + 1)}));
            check("flow_in_ready", 256'(in_if.ready), 256'(1));
            check("flow_occ", 256'(occupancy), 256'(1));
        end
        check("flow_bubble", 256'(bubble_cnt), 256'(1));
        drive(1'b0, '0, 0, 0, 1'b1);
        tick();
        check("flow_drain_valid", 256'(out_if.valid), 256'(0));
        check("flow_drain_occ", 256'(occupancy), 256'(0));

        // Stall absorbed by the skid slot.
        drive(1'b1, mk_pl(10), 10, 11, 1'b0);
        tick();
        check("stall_one_occ", 256'(occupancy), 256'(1));
        drive(1'b1, mk_pl(11), 12, 13, 1'b0);
        tick();
        check("stall_two_in_ready", 256'(in_if.ready), 256'(0));
        check("stall_two_payload", 256'(out_if.payload), 256'(mk_pl(10)));
        check("stall_two_occ", 256'(occupancy), 256'(2));
        drive(1'b1, mk_pl(12), 14, 15, 1'b0);
        tick();
        check("stall_hold_payload", 256'(out_if.payload), 256'(mk_pl(10)));
        check("stall_hold_occ", 256'(occupancy), 256'(2));
        drive(1'b0, '0, 0, 0, 1'b1);
        tick();
        check("stall_release_payload", 256'(out_if.payload), 256'(mk_pl(11)));
        check("stall_release_src", 256'({out_if.src1, out_if.src2}), 256'({SW'(12), SW'(13)}));
        check("stall_release_in_ready", 256'(in_if.ready), 256'(1));
        check("stall_release_occ", 256'(occupancy), 256'(1));
        tick();
        check("stall_empty_occ", 256'(occupancy), 256'(0));

        // Flush from TWO beats a simultaneous in_fire and out_fire.
        drive(1'b1, mk_pl(20), 1, 2, 1'b0);
        tick();
        drive(1'b1, mk_pl(21), 3, 4, 1'b0);
        tick();
        check("flush_pre_occ", 256'(occupancy), 256'(2));
        flush = 1'b1;
        drive(1'b1, mk_pl(22), 5, 6, 1'b1);
        tick();
        flush = 1'b0;
        check("flush_valid", 256'(out_if.valid), 256'(0));
        check("flush_occ", 256'(occupancy), 256'(0));
        check("flush_payload", 256'(out_if.payload), 256'(0));
        check("flush_src", 256'({out_if.src1, out_if.src2}), 256'(0));
        check("flush_in_ready", 256'(in_if.ready), 256'(1));
        drive(1'b0, '0, 0, 0, 1'b1);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("flush_no_ghost", 256'(out_if.valid), 256'(0));
        end

        // Control bits stay gated while nothing valid is held.
        pl = '0;
        pl[CW-1:0] = 7'h7F;
        drive(1'b0, pl, 7, 7, 1'b0);
        tick();
        check("gate_ctrl", 256'(out_if.payload[CW-1:0]), 256'(0));
        check("gate_occ", 256'(occupancy), 256'(0));
        check("gate_valid", 256'(out_if.valid), 256'(0));

        // Asynchronous reset while TWO, between clock edges.
        drive(1'b1, mk_pl(30), 8, 9, 1'b0);
        tick();
        drive(1'b1, mk_pl(31), 10, 11, 1'b0);
        tick();
        check("arst_pre_occ", 256'(occupancy), 256'(2));
        drive(1'b0, '0, 0, 0, 1'b0);
        #2;
        rst = 1'b1;
        #1;
        check_reset_vals("arst");
        #3;
        rst = 1'b0;
        tick();
        drive(1'b1, mk_pl(40), 2, 3, 1'b1);
        tick();
        check("arst_restart_payload", 256'(out_if.payload), 256'(mk_pl(40)));
        check("arst_restart_valid", 256'(out_if.valid), 256'(1));
        check("arst_restart_bubble", 256'(bubble_cnt), 256'(2));

        // Bubble counter saturation.
        drive(1'b0, '0, 0, 0, 1'b1);
        repeat (70000) tick();
        check("sat_bubble", 256'(bubble_cnt), 256'(16'hFFFF));
        repeat (5) tick();
        check("sat_bubble_hold", 256'(bubble_cnt), 256'(16'hFFFF));

        check("sb_drained", 256'(sb_q.size()), 256'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/id_ex_skid_reg.md
# id_ex_skid_reg

Parametrised ID→EXE pipeline boundary register with a two-entry skid buffer, valid/ready handshake and synchronous flush. It replaces a plain stage register: a downstream stall no longer has to fan back combinationally into ID/IF in the same cycle. It also carries the source-register tags the hazard and forwarding units consume. It sits between the ID stage (decode plus register-file read) and the EXE stage.

## Interface
Parameters:
- PAYLOAD_W, 180, width of the packed stage payload (pc, Val_Rn, Val_Rm, instruction, shift operand, signed imm, dest, EXE_cmd, flags).
- CTRL_W, 7, number of LSBs of the payload that are control bits (WB_en, mem_read, mem_write, imm, branch, s, carry). These bits are forced to 0 whenever the output is not valid.
- SRC_W, 4, register tag width.

Ports:
- clk  in  1  clock, rising-edge.
- rst  in  1  asynchronous, active-high reset.
- flush  in  1  synchronous flush (branch taken). Empties the block.
- in_valid  in  1  ID holds a valid instruction.
- in_ready  out  1  block can accept. Registered.
- in_payload  in  PAYLOAD_W  ID payload.
- in_src1, in_src2  in  SRC_W  source register tags.
- out_valid  out  1  EXE-side entry valid.
- out_ready  in  1  EXE accepts (low = EXE/MEM freeze).
- out_payload  out  PAYLOAD_W  head entry payload. Control bits are 0 when out_valid=0.
- out_src1, out_src2  out  SRC_W  head entry tags.
- occupancy  out  2  entries held (0..2).
- bubble_cnt  out  16  count of cycles with out_valid=0. Saturating.

## Operation
- Storage: main slot (M) drives the outputs; skid slot (S) holds overflow. Each slot stores payload, src1, src2 and a valid bit.
- in_fire = in_valid & in_ready. out_fire = out_valid & out_ready.
- States, encoded by {S.v, M.v}:
  - EMPTY: in_fire → ONE (M ← in).
  - ONE: in_fire & out_fire → ONE (M ← in). in_fire & !out_fire → TWO (S ← in). !in_fire & out_fire → EMPTY. Otherwise hold.
  - TWO: out_fire → ONE (M ← S, S cleared). in_ready=0, so no input is accepted.
- No other transitions exist. M is never empty while S is valid.
- flush: on the next edge, M.v=S.v=0 and the state goes to EMPTY. Flush takes priority over in_fire and out_fire that cycle, so the incoming instruction is dropped. Stored payload and tags are cleared to 0.
- occupancy = M.v + S.v.
- bubble_cnt increments on every edge where out_valid=0 and saturates at 16'hFFFF.

## Timing
- Reset values: all slot bits are 0, state EMPTY, in_ready=1, out_valid=0, out_payload=0, out_src1=out_src2=0, occupancy=0, bubble_cnt=0. Every register, including the tags, is reset.
- Latency: 1 cycle from in_fire to out_valid when EMPTY, or when ONE with out_fire.
- in_ready is registered: in_ready(next) = !(next-state == TWO). It has no combinational path from out_ready.
- out_* come directly from M registers. The only logic in the path is the CTRL_W AND-gating with M.v.
- Throughput: 1 instruction per cycle with no stalls. A single-cycle stall costs no bubble; it is absorbed by S.
- Flush while TWO: both entries are lost. in_ready=1 the next cycle.
- rst asserted mid-transfer: the block clears immediately (asynchronously). The handshake restarts from EMPTY after deassertion.
- in_valid may drop without a fire. Payload is sampled only on in_fire.

## Structure
- Shared package pipe_pkg holds:
  - the state enum {EMPTY, ONE, TWO}
  - SRC_W
  - the CTRL bit index localparams (WB_EN_B, MEM_R_B, MEM_W_B, IMM_B, BR_B, S_B, C_B)
  - the packed ID/EXE payload struct, so ID packs and EXE unpacks consistently
- One sub-module fits naturally: pipe_slot (payload + tags + valid, with load, clear and async reset). Instantiate it twice, as M and S.
- Top level holds the state logic, in_ready register and bubble counter.

## Test plan
- Reset/flow: rst, then 4 back-to-back in_valid with payloads 1,2,3,4 and out_ready=1 → out_payload 1,2,3,4 on cycles 1–4 after first fire; in_ready stays 1; occupancy 1; bubble_cnt=1 (the cycle before the first fire).
- Stall absorb: ONE holding A, out_ready=0, in B fires → state TWO, in_ready=0 next cycle, out holds A. Then out_ready=1 → out B next cycle, in_ready=1.
- Flush priority: TWO state, flush=1 with in_valid=1 and out_ready=1 → next cycle out_valid=0, occupancy 0, out_payload=0, incoming instruction never appears.
- Control gating: in_payload control bits = 7'h7F with in_valid=0 → out_payload[6:0]=0 and no state change.
- Async reset mid-TWO: rst pulse between edges → outputs return to reset values immediately, without a clock edge.
- Counter saturation: hold in_valid=0 for 70000 cycles → bubble_cnt = 16'hFFFF and stays there.
